// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and FSM state encoding for the single-beat AXI4 master.
package axi4_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned LEN_W  = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [SIZE_W-1:0] AXI_SIZE_1B = 3'd0;
  localparam logic [SIZE_W-1:0] AXI_SIZE_2B = 3'd1;
  localparam logic [SIZE_W-1:0] AXI_SIZE_4B = 3'd2;
  localparam logic [SIZE_W-1:0] AXI_SIZE_8B = 3'd3;

  // Explicit encodings keep the legacy state values visible in waveforms.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4 initiator: turns one load/store request into one
// single-beat AXI4 read or write and returns data/error on a response port.
module axi4_lite_master
  import axi4_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID   = 4'h0,
  parameter bit              CHECK_ID = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  // core request port
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [SIZE_W-1:0]   req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [STRB_W-1:0]   req_wstrb,
  // core response port
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  // write address channel
  input  logic                awready_i,
  output logic                awvalid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [ID_W-1:0]     awid_o,
  output logic [LEN_W-1:0]    awlen_o,
  output logic [SIZE_W-1:0]   awsize_o,
  output logic [1:0]          awburst_o,
  // write data channel
  input  logic                wready_i,
  output logic                wvalid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [STRB_W-1:0]   wstrb_o,
  output logic                wlast_o,
  // write response channel
  output logic                bready_o,
  input  logic                bvalid_i,
  input  logic [1:0]          bresp_i,
  input  logic [ID_W-1:0]     bid_i,
  // read address channel
  input  logic                arready_i,
  output logic                arvalid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [ID_W-1:0]     arid_o,
  output logic [LEN_W-1:0]    arlen_o,
  output logic [SIZE_W-1:0]   arsize_o,
  output logic [1:0]          arburst_o,
  // read data channel
  output logic                rready_o,
  input  logic                rvalid_i,
  input  logic [1:0]          rresp_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                rlast_i,
  input  logic [ID_W-1:0]     rid_i
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  // Next-state, request latching and response capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          if (req_we) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (arready_i) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (rvalid_i) begin
          rdata_d = rdata_i;
          err_d   = (rresp_i != AXI_RESP_OKAY)
                  | (CHECK_ID && (rid_i != AXI_ID))
                  | ~rlast_i;
          state_d = ST_RESP;
        end
      end
      ST_WR_REQ: begin
        // AW and W handshake independently; leave once neither is pending,
        // which also covers both completing in the same cycle.
        aw_pend_d = aw_pend_q & ~awready_i;
        w_pend_d  = w_pend_q & ~wready_i;
        if (!aw_pend_d && !w_pend_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (bvalid_i) begin
          rdata_d = '0;
          err_d   = (bresp_i != AXI_RESP_OKAY)
                  | (CHECK_ID && (bid_i != AXI_ID));
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign awvalid_o  = (state_q == ST_WR_REQ) && aw_pend_q;
  assign awaddr_o   = addr_q;
  assign awid_o     = AXI_ID;
  assign awlen_o    = '0;
  assign awsize_o   = size_q;
  assign awburst_o  = AXI_BURST_INCR;

  assign wvalid_o   = (state_q == ST_WR_REQ) && w_pend_q;
  assign wdata_o    = wdata_q;
  assign wstrb_o    = wstrb_q;
  assign wlast_o    = 1'b1;

  assign bready_o   = (state_q == ST_WR_RESP);

  assign arvalid_o  = (state_q == ST_RD_ADDR);
  assign araddr_o   = addr_q;
  assign arid_o     = AXI_ID;
  assign arlen_o    = '0;
  assign arsize_o   = size_q;
  assign arburst_o  = AXI_BURST_INCR;

  assign rready_o   = (state_q == ST_RD_DATA);

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: directed cases then randomized
// transactions, with expectations computed from the AXI response rules.
module tb_axi4_lite_master;
  import axi4_pkg::*;

  localparam logic [3:0] TB_ID = 4'h5;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        awready_i, awvalid_o;
  logic [31:0] awaddr_o;
  logic [3:0]  awid_o;
  logic [7:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        wready_i, wvalid_o, wlast_o;
  logic [63:0] wdata_o;
  logic [7:0]  wstrb_o;
  logic        bready_o, bvalid_i;
  logic [1:0]  bresp_i;
  logic [3:0]  bid_i;
  logic        arready_i, arvalid_o;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        rready_o, rvalid_i, rlast_i;
  logic [1:0]  rresp_i;
  logic [63:0] rdata_i;
  logic [3:0]  rid_i;

  int checks   = 0;
  int failures = 0;

  axi4_lite_master #(.AXI_ID(TB_ID), .CHECK_ID(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awready_i(awready_i), .awvalid_o(awvalid_o), .awaddr_o(awaddr_o),
    .awid_o(awid_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o),
    .wready_i(wready_i), .wvalid_o(wvalid_o), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .bready_o(bready_o), .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bid_i(bid_i),
    .arready_i(arready_i), .arvalid_o(arvalid_o), .araddr_o(araddr_o),
    .arid_o(arid_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o),
    .rready_o(rready_o), .rvalid_i(rvalid_i), .rresp_i(rresp_i),
    .rdata_i(rdata_i), .rlast_i(rlast_i), .rid_i(rid_i)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [63:0] wd, input logic [7:0] ws);
    int unsigned n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_wdata = wd; req_wstrb = ws;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_before_accept", req_ready, 1);
    tick();
    // scramble request fields: outputs must come from the latched copy
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
    req_size = 3'($urandom); req_wdata = {$urandom, $urandom}; req_wstrb = 8'($urandom);
    check("req_ready_after_accept", req_ready, 0);
  endtask

  task automatic finish_resp(input logic [63:0] exp_data, input logic exp_err,
                             input int unsigned resp_dly);
    for (int i = 0; i <= int'(resp_dly); i++) begin
      check("resp_valid", resp_valid, 1);
      check("resp_rdata", resp_rdata, exp_data);
      check("resp_err", resp_err, exp_err);
      check("resp_req_ready_low", req_ready, 0);
      resp_ready = (i == int'(resp_dly));
      tick();
    end
    resp_ready = 1'b0;
    check("resp_valid_dropped", resp_valid, 0);
    check("req_ready_after_resp", req_ready, 1);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [2:0] size,
                          input int unsigned ar_dly, input int unsigned r_dly,
                          input logic [63:0] rd, input logic [1:0] rresp,
                          input logic [3:0] rid, input logic rlast,
                          input int unsigned resp_dly);
    logic exp_err;
    exp_err = (rresp != AXI_RESP_OKAY) || (rid != TB_ID) || !rlast;
    issue(1'b0, addr, size, {$urandom, $urandom}, 8'($urandom));
    check("rd_awvalid_low", awvalid_o, 0);
    for (int i = 0; i <= int'(ar_dly); i++) begin
      check("rd_arvalid", arvalid_o, 1);
      check("rd_araddr", araddr_o, addr);
      check("rd_arsize", arsize_o, size);
      check("rd_arlen", arlen_o, 0);
      check("rd_arburst", arburst_o, AXI_BURST_INCR);
      check("rd_arid", arid_o, TB_ID);
      check("rd_rready_low", rready_o, 0);
      arready_i = (i == int'(ar_dly));
      rvalid_i  = (i != int'(ar_dly)) && ($urandom_range(0, 1) == 1);
      rdata_i   = {$urandom, $urandom};
      tick();
    end
    arready_i = 1'b0;
    rvalid_i  = 1'b0;
    check("rd_arvalid_dropped", arvalid_o, 0);
    for (int i = 0; i <= int'(r_dly); i++) begin
      check("rd_rready", rready_o, 1);
      check("rd_resp_valid_low", resp_valid, 0);
      rvalid_i = (i == int'(r_dly));
      rdata_i  = rd; rresp_i = rresp; rid_i = rid; rlast_i = rlast;
      bvalid_i = $urandom_range(0, 1);
      tick();
    end
    rvalid_i = 1'b0; bvalid_i = 1'b0;
    rdata_i = {$urandom, $urandom}; rresp_i = 2'($urandom); rid_i = 4'($urandom);
    rlast_i = 1'($urandom);
    check("rd_rready_dropped", rready_o, 0);
    finish_resp(rd, exp_err, resp_dly);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [2:0] size,
                           input logic [63:0] wd, input logic [7:0] ws,
                           input int unsigned aw_dly, input int unsigned w_dly,
                           input int unsigned b_dly, input logic [1:0] bresp,
                           input logic [3:0] bid, input int unsigned resp_dly);
    logic exp_err;
    int   last;
    exp_err = (bresp != AXI_RESP_OKAY) || (bid != TB_ID);
    last = (aw_dly > w_dly) ? int'(aw_dly) : int'(w_dly);
    issue(1'b1, addr, size, wd, ws);
    check("wr_arvalid_low", arvalid_o, 0);
    for (int k = 0; k <= last; k++) begin
      check("wr_awvalid", awvalid_o, (k <= int'(aw_dly)));
      check("wr_wvalid", wvalid_o, (k <= int'(w_dly)));
      check("wr_bready_low", bready_o, 0);
      if (k <= int'(aw_dly)) begin
        check("wr_awaddr", awaddr_o, addr);
        check("wr_awsize", awsize_o, size);
        check("wr_awlen", awlen_o, 0);
        check("wr_awburst", awburst_o, AXI_BURST_INCR);
        check("wr_awid", awid_o, TB_ID);
      end
      if (k <= int'(w_dly)) begin
        check("wr_wdata", wdata_o, wd);
        check("wr_wstrb", wstrb_o, ws);
        check("wr_wlast", wlast_o, 1);
      end
      awready_i = (k == int'(aw_dly));
      wready_i  = (k == int'(w_dly));
      bvalid_i  = $urandom_range(0, 1);
      rvalid_i  = $urandom_range(0, 1);
      tick();
    end
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; rvalid_i = 1'b0;
    check("wr_awvalid_dropped", awvalid_o, 0);
    check("wr_wvalid_dropped", wvalid_o, 0);
    for (int i = 0; i <= int'(b_dly); i++) begin
      check("wr_bready", bready_o, 1);
      check("wr_resp_valid_low", resp_valid, 0);
      bvalid_i = (i == int'(b_dly));
      bresp_i = bresp; bid_i = bid;
      rvalid_i = $urandom_range(0, 1);
      tick();
    end
    bvalid_i = 1'b0; rvalid_i = 1'b0; bresp_i = 2'($urandom); bid_i = 4'($urandom);
    check("wr_bready_dropped", bready_o, 0);
    finish_resp(64'h0, exp_err, resp_dly);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_size = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 0; awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = '0; bid_i = '0;
    arready_i = 0; rvalid_i = 0; rresp_i = '0; rdata_i = '0; rlast_i = 0; rid_i = '0;
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o}, 0);
    reset = 1'b0;
    tick();

    // Zero-wait read
    run_read(32'h8000_0010, AXI_SIZE_8B, 0, 0, 64'h1122334455667788,
             AXI_RESP_OKAY, TB_ID, 1'b1, 0);
    // Write with AW and W accepted together
    run_write(32'h8000_0004, AXI_SIZE_8B, 64'hDEADBEEF_00000000, 8'hF0,
              0, 0, 0, AXI_RESP_OKAY, TB_ID, 0);
    // Split AW/W handshakes
    run_write(32'h8000_0100, AXI_SIZE_4B, 64'h0123_4567_89AB_CDEF, 8'h0F,
              1, 4, 0, AXI_RESP_OKAY, TB_ID, 0);
    // W before AW
    run_write(32'h0000_0003, AXI_SIZE_1B, 64'h0000_0000_0000_00AA, 8'h08,
              3, 1, 2, AXI_RESP_OKAY, TB_ID, 1);
    // Error paths
    run_read(32'h1000_0000, AXI_SIZE_8B, 0, 1, 64'hCAFE_F00D_0000_0001,
             AXI_RESP_SLVERR, TB_ID, 1'b1, 0);
    run_write(32'h1000_0008, AXI_SIZE_8B, 64'h5555_AAAA_5555_AAAA, 8'hFF,
              0, 0, 0, AXI_RESP_OKAY, 4'h3, 0);
    run_read(32'h1000_0010, AXI_SIZE_2B, 1, 0, 64'h0000_0000_0000_BEEF,
             AXI_RESP_OKAY, TB_ID, 1'b0, 0);
    run_read(32'h1000_0018, AXI_SIZE_8B, 0, 0, 64'h7777_6666_5555_4444,
             AXI_RESP_OKAY, 4'h0, 1'b1, 0);
    // Response backpressure for 5 cycles
    run_read(32'h2000_0020, AXI_SIZE_8B, 0, 0, 64'hA5A5_5A5A_F0F0_0F0F,
             AXI_RESP_OKAY, TB_ID, 1'b1, 5);

    // Reset while waiting for read data with rvalid_i pending
    issue(1'b0, 32'h3000_0000, AXI_SIZE_8B, '0, '0);
    arready_i = 1'b1; tick(); arready_i = 1'b0;
    check("mid_rst_in_rd_data", rready_o, 1);
    rvalid_i = 1'b1; rdata_i = 64'hBAD0_BAD0_BAD0_BAD0; rresp_i = AXI_RESP_OKAY;
    rid_i = TB_ID; rlast_i = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valids", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, resp_valid}, 0);
    check("mid_rst_rdata", resp_rdata, 0);
    check("mid_rst_req_ready", req_ready, 1);
    tick();
    check("mid_rst_rvalid_ignored", resp_valid, 0);
    check("mid_rst_rdata_kept", resp_rdata, 0);
    rvalid_i = 1'b0;
    run_read(32'h3000_0008, AXI_SIZE_8B, 0, 0, 64'h0F1E_2D3C_4B5A_6978,
             AXI_RESP_OKAY, TB_ID, 1'b1, 0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  rsp;
      logic [3:0]  id;
      a   = $urandom;
      sz  = 3'($urandom_range(0, 3));
      rsp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : AXI_RESP_OKAY;
      id  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : TB_ID;
      if ($urandom_range(0, 1) == 1)
        run_write(a, sz, {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  rsp, id, $urandom_range(0, 3));
      else
        run_read(a, sz, $urandom_range(0, 3), $urandom_range(0, 3),
                 {$urandom, $urandom}, rsp, id, ($urandom_range(0, 5) != 0),
                 $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
